// File: rtl/playback_controller_pkg.sv
// Shared constants, state encodings and repeat-mode codes for the auto-mode playback sequencer.
package playback_controller_pkg;
  localparam int SONG_BITS     = 3;
  localparam int SONG_CNT_BITS = 8;
  localparam logic [SONG_BITS-1:0] NO_SONG = '1;

  typedef enum logic [2:0] {PB_IDLE, PB_LOAD, PB_PLAY, PB_GAP, PB_PAUSE} pb_state_t;

  localparam logic [1:0] RPT_STOP = 2'b00;
  localparam logic [1:0] RPT_ONE  = 2'b01;
  localparam logic [1:0] RPT_ALL  = 2'b10;
endpackage

// File: rtl/playback_controller_if.sv
// Button/ROM/sound-engine bundle of the playback controller; master drives controls, slave is the controller.
interface playback_controller_if #(
  parameter int SONG_W = playback_controller_pkg::SONG_BITS,
  parameter int CNT_W  = playback_controller_pkg::SONG_CNT_BITS
);
  logic              en;
  logic [SONG_W-1:0] song_sel;
  logic              play_btn;
  logic              next_btn;
  logic              prev_btn;
  logic [1:0]        repeat_mode;
  logic [CNT_W-1:0]  track_len;
  logic              note_done;
  logic [SONG_W-1:0] song_idx;
  logic [CNT_W-1:0]  note_idx;
  logic              note_req;
  logic              note_abort;
  logic              playing;
  logic              mute;

  modport master (
    output en, song_sel, play_btn, next_btn, prev_btn, repeat_mode, track_len, note_done,
    input  song_idx, note_idx, note_req, note_abort, playing, mute
  );
  modport slave (
    input  en, song_sel, play_btn, next_btn, prev_btn, repeat_mode, track_len, note_done,
    output song_idx, note_idx, note_req, note_abort, playing, mute
  );
endinterface

// File: rtl/playback_controller_gap_timer.sv
// Silent-gap down-counter between notes: load arms it, count decrements, expire flags the last gap cycle.
module playback_controller_gap_timer #(
  parameter int GAP_CYCLES = 2500000,
  localparam int W = $clog2(GAP_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expire
);
  logic [W-1:0] cnt;

  // Loaded with GAP_CYCLES-1 so the timer reads zero in the final gap cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= W'(GAP_CYCLES - 1);
    else if (count && cnt != 0) cnt <= cnt - 1'b1;

  assign expire = (cnt == '0);
endmodule

// File: rtl/playback_controller.sv
// Auto-mode song sequencer driving Song ROM addresses and the Sound engine start/done handshake.
// Optional inter-note silent gap compiled in with NOTE_GAP_EN.
module playback_controller
  import playback_controller_pkg::*;
#(
  parameter int SONG_W     = SONG_BITS,
  parameter int CNT_W      = SONG_CNT_BITS,
  parameter int NUM_SONGS  = 4,
  parameter int GAP_CYCLES = 2500000
) (
  input  logic                 clk,
  input  logic                 rst,
  playback_controller_if.slave bus
);
  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [SONG_W-1:0] NONE      = SONG_W'(NO_SONG);

  pb_state_t         state, nxt_state;
  logic [SONG_W-1:0] nxt_song, song_inc, song_dec;
  logic [CNT_W-1:0]  nxt_note;
  logic              pause_pending, nxt_pp, nxt_abort;

  assign song_inc = (bus.song_idx >= LAST_SONG) ? '0 : bus.song_idx + 1'b1;
  assign song_dec = (bus.song_idx == '0 || bus.song_idx > LAST_SONG) ? LAST_SONG : bus.song_idx - 1'b1;

`ifdef NOTE_GAP_EN
  logic gap_load, gap_expire;

  playback_controller_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
    .clk   (clk),
    .rst   (rst),
    .load  (gap_load),
    .count (state == PB_GAP),
    .expire(gap_expire)
  );
`else
  wire unused_gap_cfg = ^GAP_CYCLES;
`endif

  always_comb begin
    nxt_state = state;
    nxt_song  = bus.song_idx;
    nxt_note  = bus.note_idx;
    nxt_pp    = pause_pending;
    nxt_abort = 1'b0;
`ifdef NOTE_GAP_EN
    gap_load  = 1'b0;
`endif
    if (!bus.en) begin
      nxt_state = PB_IDLE;
      nxt_note  = '0;
      nxt_pp    = 1'b0;
      nxt_abort = (state == PB_PLAY);
      if (state == PB_IDLE) nxt_song = bus.song_sel;
    end else if (state == PB_IDLE) begin
      nxt_song = bus.song_sel;
      nxt_note = '0;
      if (bus.play_btn && bus.song_sel != NONE) nxt_state = PB_LOAD;
    end else if (bus.next_btn || bus.prev_btn) begin
      nxt_song  = bus.next_btn ? song_inc : song_dec;
      nxt_note  = '0;
      nxt_pp    = 1'b0;
      nxt_state = PB_LOAD;
      nxt_abort = (state == PB_PLAY);
    end else begin
      case (state)
        PB_LOAD: nxt_state = PB_PLAY;
        PB_PLAY:
          // A pause request wins over a coincident note_done, which is dropped.
          if (bus.play_btn) nxt_pp = 1'b1;
          else if (bus.note_done) begin
            if (bus.note_idx < bus.track_len) begin
              nxt_note = bus.note_idx + 1'b1;
              if (pause_pending) begin
                nxt_state = PB_PAUSE;
                nxt_pp    = 1'b0;
              end else begin
`ifdef NOTE_GAP_EN
                nxt_state = PB_GAP;
                gap_load  = 1'b1;
`else
                nxt_state = PB_LOAD;
`endif
              end
            end else begin
              nxt_note = '0;
              case (bus.repeat_mode)
                RPT_ONE: nxt_state = PB_LOAD;
                RPT_ALL: begin
                  nxt_song  = song_inc;
                  nxt_state = PB_LOAD;
                end
                default: begin
                  nxt_state = PB_IDLE;
                  nxt_pp    = 1'b0;
                end
              endcase
              if (nxt_state == PB_LOAD && pause_pending) begin
                nxt_state = PB_PAUSE;
                nxt_pp    = 1'b0;
              end
            end
          end
`ifdef NOTE_GAP_EN
        PB_GAP:
          if (bus.play_btn)     nxt_state = PB_PAUSE;
          else if (gap_expire)  nxt_state = PB_LOAD;
`endif
        PB_PAUSE: if (bus.play_btn) nxt_state = PB_LOAD;
        default:  nxt_state = PB_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet aligned with it.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state          <= PB_IDLE;
      pause_pending  <= 1'b0;
      bus.song_idx   <= '0;
      bus.note_idx   <= '0;
      bus.note_req   <= 1'b0;
      bus.note_abort <= 1'b0;
      bus.playing    <= 1'b0;
      bus.mute       <= 1'b1;
    end else begin
      state          <= nxt_state;
      pause_pending  <= nxt_pp;
      bus.song_idx   <= nxt_song;
      bus.note_idx   <= nxt_note;
      bus.note_req   <= (nxt_state == PB_LOAD);
      bus.note_abort <= nxt_abort;
      bus.playing    <= (nxt_state == PB_LOAD) || (nxt_state == PB_PLAY) || (nxt_state == PB_GAP);
      bus.mute       <= (nxt_state != PB_PLAY);
    end
endmodule
